barrier_sync_unit: RTL

BARRIER_SYNC_UNIT -- requirements
Module: barrier_sync_unit

---
 rtl/barrier_sync_unit.sv | 240 ++++++++++++++++++++++++
 1 files changed

// File: rtl/barrier_sync_unit.sv
// Barrier synchronisation unit.
//
// Each barrier ID runs its own small FSM (idle / gather / release / abort). TPCs raise a
// level request tagged with a barrier ID; the barrier snapshots the enabled TPCs as its
// member set on the first arrival, collects arrivals, and releases every member with a
// one-cycle grant once all have arrived. An optional gather timeout aborts an incomplete
// episode and latches a sticky error record describing the first failure.
//
// Parameters:
//   NUM_TPCS      number of TPC sync ports
//   NUM_BARRIERS  number of independent barrier IDs
//   TMO_W         width of the gather timeout counter
//
// Ports:
//   clk              clock, all logic on the rising edge
//   rst_n            synchronous active-low reset
//   tpc_enable       participating-TPC mask, snapshotted on gather entry
//   sync_request     level request per TPC, held until grant or abort
//   sync_barrier_id  barrier ID per TPC, TPC i at [i*BID_W +: BID_W]
//   timeout_cycles   gather timeout in cycles, 0 disables
//   err_clear        pulse clearing the error record
//   sync_grant       one-cycle release pulse per TPC
//   sync_abort       one-cycle timeout-abort pulse per TPC
//   barrier_active   barrier is gathering
//   global_sync_out  one-cycle pulse per barrier on release
//   timeout_err      sticky timeout flag
//   err_barrier      ID of the first timed-out barrier
//   err_missing      members that had not arrived at that timeout
//   release_count    total releases across all barriers, wrapping at 16 bits
module barrier_sync_unit #(
  parameter int unsigned NUM_TPCS     = 4,
  parameter int unsigned NUM_BARRIERS = 2,
  parameter int unsigned TMO_W        = 16,
  localparam int unsigned BID_W       = (NUM_BARRIERS > 1) ? $clog2(NUM_BARRIERS) : 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_TPCS-1:0]       tpc_enable,
  input  logic [NUM_TPCS-1:0]       sync_request,
  input  logic [NUM_TPCS*BID_W-1:0] sync_barrier_id,
  input  logic [TMO_W-1:0]          timeout_cycles,
  input  logic                      err_clear,
  output logic [NUM_TPCS-1:0]       sync_grant,
  output logic [NUM_TPCS-1:0]       sync_abort,
  output logic [NUM_BARRIERS-1:0]   barrier_active,
  output logic [NUM_BARRIERS-1:0]   global_sync_out,
  output logic                      timeout_err,
  output logic [BID_W-1:0]          err_barrier,
  output logic [NUM_TPCS-1:0]       err_missing,
  output logic [15:0]               release_count
);

  typedef enum logic [1:0] {
    StIdle,
    StGather,
    StRelease,
    StAbort
  } state_e;

  // Per-barrier state
  state_e              state_q   [NUM_BARRIERS];
  state_e              state_d   [NUM_BARRIERS];
  logic [NUM_TPCS-1:0] member_q  [NUM_BARRIERS];
  logic [NUM_TPCS-1:0] member_d  [NUM_BARRIERS];
  logic [NUM_TPCS-1:0] arrived_q [NUM_BARRIERS];
  logic [NUM_TPCS-1:0] arrived_d [NUM_BARRIERS];
  logic [TMO_W-1:0]    tmo_q     [NUM_BARRIERS];
  logic [TMO_W-1:0]    tmo_d     [NUM_BARRIERS];

  // Per-barrier combinational helpers
  logic [NUM_TPCS-1:0] id_hit      [NUM_BARRIERS];
  logic [NUM_TPCS-1:0] arrivals    [NUM_BARRIERS];
  logic [NUM_TPCS-1:0] gathered    [NUM_BARRIERS];
  logic [NUM_TPCS-1:0] hit_missing [NUM_BARRIERS];
  logic [NUM_BARRIERS-1:0] timeout_hit;

  // Shared state
  logic [NUM_TPCS-1:0] armed_q, armed_d;
  logic [NUM_TPCS-1:0] busy, eligible;
  logic                timeout_err_q, timeout_err_d;
  logic [BID_W-1:0]    err_barrier_q, err_barrier_d;
  logic [NUM_TPCS-1:0] err_missing_q, err_missing_d;
  logic [15:0]         release_count_q, release_count_d;
  logic [15:0]         rel_inc;

  // Arrival qualification. A TPC already counted by some barrier is busy until that
  // barrier finishes, so retargeting its ID cannot make it arrive a second time.
  always_comb begin
    busy = '0;
    for (int b = 0; b < NUM_BARRIERS; b++) begin
      busy = busy | arrived_q[b];
    end
    eligible = sync_request & armed_q & ~busy;

    for (int b = 0; b < NUM_BARRIERS; b++) begin
      id_hit[b] = '0;
      for (int i = 0; i < NUM_TPCS; i++) begin
        id_hit[b][i] = (sync_barrier_id[i*BID_W +: BID_W] == BID_W'(b));
      end
      case (state_q[b])
        StIdle:   arrivals[b] = eligible & id_hit[b] & tpc_enable;
        StGather: arrivals[b] = eligible & id_hit[b] & member_q[b];
        default:  arrivals[b] = '0;
      endcase
      gathered[b] = arrived_q[b] | arrivals[b];
    end
  end

  // Per-barrier next-state logic
  always_comb begin
    timeout_hit = '0;
    for (int b = 0; b < NUM_BARRIERS; b++) begin
      state_d[b]     = state_q[b];
      member_d[b]    = member_q[b];
      arrived_d[b]   = arrived_q[b];
      tmo_d[b]       = tmo_q[b];
      hit_missing[b] = '0;

      case (state_q[b])
        StIdle: begin
          if (arrivals[b] != '0) begin
            member_d[b]  = tpc_enable;
            arrived_d[b] = arrivals[b];
            tmo_d[b]     = '0;
            // Everyone enabled may arrive on the very first edge.
            state_d[b]   = (arrivals[b] == tpc_enable) ? StRelease : StGather;
          end
        end
        StGather: begin
          arrived_d[b] = gathered[b];
          if (gathered[b] == member_q[b]) begin
            // Completion wins over a timeout on the same edge.
            state_d[b] = StRelease;
          end else if (timeout_cycles != '0) begin
            if (tmo_q[b] == timeout_cycles - TMO_W'(1)) begin
              state_d[b]     = StAbort;
              timeout_hit[b] = 1'b1;
              hit_missing[b] = member_q[b] & ~gathered[b];
            end else begin
              tmo_d[b] = tmo_q[b] + TMO_W'(1);
            end
          end
        end
        StRelease, StAbort: begin
          state_d[b]   = StIdle;
          arrived_d[b] = '0;
        end
        default: begin
          state_d[b]   = StIdle;
          arrived_d[b] = '0;
        end
      endcase
    end
  end

  // Pulse and status outputs decode directly from the registered state.
  always_comb begin
    sync_grant      = '0;
    sync_abort      = '0;
    barrier_active  = '0;
    global_sync_out = '0;
    rel_inc         = '0;
    for (int b = 0; b < NUM_BARRIERS; b++) begin
      if (state_q[b] == StRelease) begin
        sync_grant         = sync_grant | member_q[b];
        global_sync_out[b] = 1'b1;
        rel_inc            = rel_inc + 16'd1;
      end
      if (state_q[b] == StAbort) begin
        sync_abort = sync_abort | arrived_q[b];
      end
      barrier_active[b] = (state_q[b] == StGather);
    end
  end

  // A TPC that saw a grant or abort stays disarmed until its request is seen low.
  always_comb begin
    armed_d         = (armed_q & ~(sync_grant | sync_abort)) | ~sync_request;
    release_count_d = release_count_q + rel_inc;
  end

  // Error record: first timeout is sticky; lowest barrier wins a tie; a new timeout
  // coinciding with err_clear replaces the record instead of being lost.
  always_comb begin
    logic found;
    found         = 1'b0;
    timeout_err_d = timeout_err_q;
    err_barrier_d = err_barrier_q;
    err_missing_d = err_missing_q;
    if (err_clear) begin
      timeout_err_d = 1'b0;
      err_barrier_d = '0;
      err_missing_d = '0;
    end
    if (!timeout_err_q || err_clear) begin
      for (int b = 0; b < NUM_BARRIERS; b++) begin
        if (timeout_hit[b] && !found) begin
          found         = 1'b1;
          timeout_err_d = 1'b1;
          err_barrier_d = BID_W'(b);
          err_missing_d = hit_missing[b];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int b = 0; b < NUM_BARRIERS; b++) begin
        state_q[b]   <= StIdle;
        member_q[b]  <= '0;
        arrived_q[b] <= '0;
        tmo_q[b]     <= '0;
      end
      armed_q         <= '1;
      timeout_err_q   <= 1'b0;
      err_barrier_q   <= '0;
      err_missing_q   <= '0;
      release_count_q <= '0;
    end else begin
      for (int b = 0; b < NUM_BARRIERS; b++) begin
        state_q[b]   <= state_d[b];
        member_q[b]  <= member_d[b];
        arrived_q[b] <= arrived_d[b];
        tmo_q[b]     <= tmo_d[b];
      end
      armed_q         <= armed_d;
      timeout_err_q   <= timeout_err_d;
      err_barrier_q   <= err_barrier_d;
      err_missing_q   <= err_missing_d;
      release_count_q <= release_count_d;
    end
  end

  assign timeout_err   = timeout_err_q;
  assign err_barrier   = err_barrier_q;
  assign err_missing   = err_missing_q;
  assign release_count = release_count_q;

endmodule
